subneg_mem_arb: RTL

SUBNEG_MEM_ARB -- requirements
Module: subneg_mem_arb

---
 rtl/subneg_pkg.sv | 32 +++
 rtl/subneg_mem_arb.sv | 109 ++++++++++
 2 files changed

// File: rtl/subneg_pkg.sv
// Shared types for the subneg memory arbiter: FSM states, owner encoding and
// the grant strobes produced by the control FSM.
package subneg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CORE_ISS,
    CORE_RSP,
    HOST_ISS,
    HOST_RSP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_HOST = 2'b10
  } owner_t;

  typedef struct packed {
    logic core;
    logic host;
  } grant_t;

  function automatic owner_t owner_of(arb_state_t s);
    case (s)
      CORE_ISS, CORE_RSP: return OWN_CORE;
      HOST_ISS, HOST_RSP: return OWN_HOST;
      default:            return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/subneg_mem_arb.sv
// Two-requester arbiter (core, host) in front of a single-port synchronous RAM.
// Core has priority and may lock the RAM across chained accesses; a starvation counter lets the host in.
module subneg_mem_arb
  import subneg_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_lock,
  output logic          core_ack,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_t    state, state_nx;
  grant_t        grant;
  logic [SW-1:0] starve_cnt;

  always_comb begin
    state_nx = state;
    grant    = '0;
    case (state)
      IDLE: begin
        if (core_req && host_req) begin
          if (starve_cnt == STARVE_TOP) begin
            state_nx   = HOST_ISS;
            grant.host = 1'b1;
          end else begin
            state_nx   = CORE_ISS;
            grant.core = 1'b1;
          end
        end else if (core_req) begin
          state_nx   = CORE_ISS;
          grant.core = 1'b1;
        end else if (host_req) begin
          state_nx   = HOST_ISS;
          grant.host = 1'b1;
        end
      end
      CORE_ISS: state_nx = CORE_RSP;
      HOST_ISS: state_nx = HOST_RSP;
      // A locked core chains straight back in; the starvation counter is not consulted here.
      CORE_RSP: begin
        if (core_lock && core_req) begin
          state_nx   = CORE_ISS;
          grant.core = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      HOST_RSP: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (grant.core) begin
        mem_we    <= core_we;
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
        if (host_req && starve_cnt != STARVE_TOP)
          starve_cnt <= starve_cnt + 1'b1;
      end else if (grant.host) begin
        mem_we     <= host_we;
        mem_addr   <= host_addr;
        mem_wdata  <= host_wdata;
        starve_cnt <= '0;
      end
    end
  end

  // Outputs decode the registered state, so an asynchronous reset clears them at once.
  assign mem_en     = (state == CORE_ISS) || (state == HOST_ISS);
  assign core_ack   = (state == CORE_RSP);
  assign host_ack   = (state == HOST_RSP);
  assign core_rdata = (core_ack && !mem_we) ? mem_rdata : '0;
  assign host_rdata = (host_ack && !mem_we) ? mem_rdata : '0;
  assign owner      = owner_of(state);

endmodule
